// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller.
//   stateT      : FSM state encoding (IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4)
//   BCD_W       : bits per BCD digit
//   NUM_DIGITS  : number of BCD digits in the score
//   SCORE_MAX   : saturation value of the score (9999 in BCD)
//   bcdGreater  : digit-wise BCD magnitude compare
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4
  } stateT;

  localparam int          BCD_W      = 4;
  localparam int          NUM_DIGITS = 4;
  localparam logic [15:0] SCORE_MAX  = 16'h9999;

  // Most significant differing digit decides the result.
  function automatic logic bcdGreater(input logic [15:0] a, input logic [15:0] b);
    logic result;
    logic decided;
    result  = 1'b0;
    decided = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      if (!decided && (a[d*BCD_W +: BCD_W] != b[d*BCD_W +: BCD_W])) begin
        result  = (a[d*BCD_W +: BCD_W] > b[d*BCD_W +: BCD_W]);
        decided = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_inc4.sv
// Combinational saturating 4-digit BCD incrementer.
//   valueIn  : current BCD value (four digits)
//   valueOut : valueIn + 1 with per-digit carry, held at 9999
module bcd_inc4
  import pong_pkg::*;
(
  input  logic [15:0] valueIn,
  output logic [15:0] valueOut
);

  // carry[gi] is the carry into digit gi; the +1 enters at digit 0.
  logic [NUM_DIGITS-1:0] carry;
  logic [15:0]           sum;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [BCD_W-1:0] digit;
      assign digit = valueIn[gi*BCD_W +: BCD_W];
      assign sum[gi*BCD_W +: BCD_W] = carry[gi]
                                      ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                                      : digit;
      if (gi < NUM_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & (digit == 4'd9);
      end
    end
  endgenerate

  assign valueOut = (valueIn == SCORE_MAX) ? valueIn : sum;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/lose FSM, paddle position, BCD score,
// lives, ball speed and optional high score.
// Optional feature: define PONG_HISCORE_EN to keep a BCD high score that is
// updated on entry to OVER; otherwise hiscore is constant zero.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   frame_tick              : one-cycle pulse per video frame
//   btn_serve/up/down       : raw buttons (synchronized here)
//   hit, miss               : ball/paddle events, honoured only in PLAY
//   state                   : FSM state code
//   ball_en, ball_reset     : ball engine controls
//   paddle_y                : paddle top row
//   speed, lives            : ball speed 1..7, remaining lives
//   score, hiscore          : four-digit BCD values
//   game_over               : high in OVER
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_STEP  = 4,
  parameter int PADDLE_MIN   = 35,
  parameter int PADDLE_MAX   = 435,
  parameter int LIVES_INIT   = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int SPEEDUP_HITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_serve,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        hit,
  input  logic        miss,
  output logic [2:0]  state,
  output logic        ball_en,
  output logic        ball_reset,
  output logic [9:0]  paddle_y,
  output logic [2:0]  speed,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic        game_over
);

  localparam int PAUSE_W = $clog2(PAUSE_FRAMES + 1);
  localparam int HIT_W   = $clog2(SPEEDUP_HITS + 1);

  localparam logic [9:0]         PADDLE_INIT = 10'((PADDLE_MIN + PADDLE_MAX) / 2);
  localparam logic [9:0]         MIN10       = 10'(PADDLE_MIN);
  localparam logic [9:0]         MAX10       = 10'(PADDLE_MAX);
  localparam logic [9:0]         STEP10      = 10'(PADDLE_STEP);
  // 11-bit limits so the clamp tests can never wrap.
  localparam logic [10:0]        UP_LIMIT    = 11'(PADDLE_MIN + PADDLE_STEP);
  localparam logic [10:0]        STEP11      = 11'(PADDLE_STEP);
  localparam logic [10:0]        MAX11       = 11'(PADDLE_MAX);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST  = PAUSE_W'(PAUSE_FRAMES - 1);
  localparam logic [HIT_W-1:0]   HIT_LAST    = HIT_W'(SPEEDUP_HITS - 1);
  localparam logic [1:0]         LIVES_START = 2'(LIVES_INIT);

  // Button synchronizers: bit 0 serve, bit 1 up, bit 2 down.
  logic [2:0] syncMetaReg, syncOutReg;
  logic       serveDlyReg;
  logic       serveEdge, upSync, downSync;

  stateT                stateReg, stateNext;
  logic [1:0]           livesReg, livesNext;
  logic [15:0]          scoreReg, scoreNext, scoreInc;
  logic [2:0]           speedReg, speedNext;
  logic [HIT_W-1:0]     hitCntReg, hitCntNext;
  logic [PAUSE_W-1:0]   pauseReg, pauseNext;
  logic [9:0]           paddleReg, paddleNext;

  assign serveEdge = syncOutReg[0] & ~serveDlyReg;
  assign upSync    = syncOutReg[1];
  assign downSync  = syncOutReg[2];

  bcd_inc4 u_scoreInc (
    .valueIn  (scoreReg),
    .valueOut (scoreInc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMetaReg <= '0;
      syncOutReg  <= '0;
      serveDlyReg <= 1'b0;
      stateReg    <= IDLE;
      livesReg    <= LIVES_START;
      scoreReg    <= '0;
      speedReg    <= 3'd1;
      hitCntReg   <= '0;
      pauseReg    <= '0;
      paddleReg   <= PADDLE_INIT;
    end else begin
      syncMetaReg <= {btn_down, btn_up, btn_serve};
      syncOutReg  <= syncMetaReg;
      serveDlyReg <= syncOutReg[0];
      stateReg    <= stateNext;
      livesReg    <= livesNext;
      scoreReg    <= scoreNext;
      speedReg    <= speedNext;
      hitCntReg   <= hitCntNext;
      pauseReg    <= pauseNext;
      paddleReg   <= paddleNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    livesNext  = livesReg;
    scoreNext  = scoreReg;
    speedNext  = speedReg;
    hitCntNext = hitCntReg;
    pauseNext  = pauseReg;
    paddleNext = paddleReg;

    // Paddle motion is independent of the FSM transition in the same cycle.
    if (frame_tick && (stateReg == SERVE || stateReg == PLAY)) begin
      if (upSync && !downSync) begin
        paddleNext = ({1'b0, paddleReg} >= UP_LIMIT) ? paddleReg - STEP10 : MIN10;
      end else if (downSync && !upSync) begin
        paddleNext = ({1'b0, paddleReg} + STEP11 > MAX11) ? MAX10 : paddleReg + STEP10;
      end
    end

    case (stateReg)
      IDLE: begin
        if (serveEdge) begin
          stateNext  = SERVE;
          scoreNext  = '0;
          livesNext  = LIVES_START;
          speedNext  = 3'd1;
          hitCntNext = '0;
        end
      end
      SERVE: begin
        if (serveEdge) stateNext = PLAY;
      end
      PLAY: begin
        // A miss overrides a coincident hit.
        if (miss) begin
          stateNext = LOST;
          pauseNext = '0;
          if (livesReg != 2'd0) livesNext = livesReg - 2'd1;
        end else if (hit) begin
          scoreNext = scoreInc;
          if (hitCntReg == HIT_LAST) begin
            hitCntNext = '0;
            if (speedReg != 3'd7) speedNext = speedReg + 3'd1;
          end else begin
            hitCntNext = hitCntReg + 1'b1;
          end
        end
      end
      LOST: begin
        if (frame_tick) begin
          if (pauseReg == PAUSE_LAST) begin
            pauseNext = '0;
            stateNext = (livesReg != 2'd0) ? SERVE : OVER;
          end else begin
            pauseNext = pauseReg + 1'b1;
          end
        end
      end
      OVER: begin
        if (serveEdge) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef PONG_HISCORE_EN
  logic [15:0] hiscoreReg, hiscoreNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hiscoreReg <= '0;
    else        hiscoreReg <= hiscoreNext;
  end

  always_comb begin
    hiscoreNext = hiscoreReg;
    if (stateReg != OVER && stateNext == OVER && bcdGreater(scoreReg, hiscoreReg))
      hiscoreNext = scoreReg;
  end

  assign hiscore = hiscoreReg;
`else
  assign hiscore = 16'h0000;
`endif

  assign state      = stateReg;
  assign ball_en    = frame_tick & (stateReg == PLAY);
  assign ball_reset = (stateReg != PLAY);
  assign paddle_y   = paddleReg;
  assign speed      = speedReg;
  assign lives      = livesReg;
  assign score      = scoreReg;
  assign game_over  = (stateReg == OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl. A transaction-level model tracks
// the game (decimal score, lives, speed, paddle) and every transaction is
// compared against the DUT outputs.
module tb_pong_game_ctrl;

  localparam int STEP = 4, PMIN = 35, PMAX = 435, LIVES0 = 3, PAUSE = 60, SPEEDUP = 5;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_LOST = 3, S_OVER = 4;
`ifdef PONG_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, btn_serve = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic        hit = 1'b0, miss = 1'b0;
  logic [2:0]  state;
  logic        ball_en, ball_reset, game_over;
  logic [9:0]  paddle_y;
  logic [2:0]  speed;
  logic [1:0]  lives;
  logic [15:0] score, hiscore;

  pong_game_ctrl #(
    .PADDLE_STEP(STEP), .PADDLE_MIN(PMIN), .PADDLE_MAX(PMAX),
    .LIVES_INIT(LIVES0), .PAUSE_FRAMES(PAUSE), .SPEEDUP_HITS(SPEEDUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_serve(btn_serve),
    .btn_up(btn_up), .btn_down(btn_down), .hit(hit), .miss(miss),
    .state(state), .ball_en(ball_en), .ball_reset(ball_reset), .paddle_y(paddle_y),
    .speed(speed), .lives(lives), .score(score), .hiscore(hiscore), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int totalCnt = 0;
  int badCnt   = 0;
  int txnCnt   = 0;

  // Reference model state
  int mState, mLives, mScore, mSpeed, mHits, mPause, mPaddle, mHi;
  bit mUp, mDown;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, txnCnt);
    end
  endtask

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic modelReset();
    mState = S_IDLE; mLives = LIVES0; mScore = 0; mSpeed = 1; mHits = 0;
    mPause = 0; mPaddle = (PMIN + PMAX) / 2; mHi = 0;
  endtask

  // One clock of game behaviour, expressed as the rules of the game.
  task automatic modelCycle(input bit ft, input bit h, input bit m, input bit srv);
    int pre;
    pre = mState;
    if (ft && (pre == S_SERVE || pre == S_PLAY)) begin
      if (mUp && !mDown)      mPaddle = imax(mPaddle - STEP, PMIN);
      else if (mDown && !mUp) mPaddle = imin(mPaddle + STEP, PMAX);
    end
    if (pre == S_IDLE && srv) begin
      mState = S_SERVE; mScore = 0; mLives = LIVES0; mSpeed = 1; mHits = 0;
    end else if (pre == S_SERVE && srv) begin
      mState = S_PLAY;
    end else if (pre == S_PLAY && m) begin
      mState = S_LOST; mLives = mLives - 1; mPause = 0;
    end else if (pre == S_PLAY && h) begin
      mScore = imin(mScore + 1, 9999);
      mHits++;
      if (mHits == SPEEDUP) begin
        mHits = 0;
        mSpeed = imin(mSpeed + 1, 7);
      end
    end else if (pre == S_LOST && ft) begin
      mPause++;
      if (mPause == PAUSE) begin
        mPause = 0;
        if (mLives > 0) mState = S_SERVE;
        else begin
          mState = S_OVER;
          if (HI_EN && mScore > mHi) mHi = mScore;
        end
      end
    end else if (pre == S_OVER && srv) begin
      mState = S_IDLE;
    end
  endtask

  task automatic checkAll();
    check("state", 32'(state), 32'(mState));
    check("lives", 32'(lives), 32'(mLives));
    check("score", 32'(score), 32'(toBcd(mScore)));
    check("hiscore", 32'(hiscore), 32'(toBcd(mHi)));
    check("speed", 32'(speed), 32'(mSpeed));
    check("paddle_y", 32'(paddle_y), 32'(mPaddle));
    check("game_over", 32'(game_over), 32'(mState == S_OVER));
    check("ball_reset", 32'(ball_reset), 32'(mState != S_PLAY));
  endtask

  // All tasks start and end just after a falling edge.
  task automatic step(input bit ft, input bit h, input bit m, input bit quiet);
    txnCnt++;
    frame_tick = ft; hit = h; miss = m;
    #1 check("ball_en", 32'(ball_en), 32'(ft && mState == S_PLAY));
    @(negedge clk);
    frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    modelCycle(ft, h, m, 1'b0);
    checkAll();
    if (!quiet)
      $display("txn %0d: tick=%0d hit=%0d miss=%0d -> state=%0d lives=%0d score=%h speed=%0d paddle=%0d",
               txnCnt, ft, h, m, state, lives, score, speed, paddle_y);
  endtask

  task automatic pressServe(input bit withTick);
    txnCnt++;
    btn_serve = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = withTick;    // lands in the serve-edge cycle
    #1 check("ball_en", 32'(ball_en), 32'(withTick && mState == S_PLAY));
    @(negedge clk);
    frame_tick = 1'b0; btn_serve = 1'b0;
    modelCycle(withTick, 1'b0, 1'b0, 1'b1);
    checkAll();
    repeat (3) @(negedge clk);
    $display("txn %0d: serve tick=%0d -> state=%0d lives=%0d score=%h paddle=%0d",
             txnCnt, withTick, state, lives, score, paddle_y);
  endtask

  task automatic setButtons(input bit up, input bit down);
    txnCnt++;
    btn_up = up; btn_down = down; mUp = up; mDown = down;
    repeat (3) @(negedge clk);
    $display("txn %0d: buttons up=%0d down=%0d", txnCnt, up, down);
  endtask

  task automatic resetDut();
    txnCnt++;
    btn_up = 1'b0; btn_down = 1'b0; btn_serve = 1'b0; mUp = 1'b0; mDown = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #1 checkAll();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("txn %0d: reset -> state=%0d paddle=%0d lives=%0d", txnCnt, state, paddle_y, lives);
  endtask

  task automatic hitBurst(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    $display("txn %0d: hit burst n=%0d -> score=%h speed=%0d", txnCnt, n, score, speed);
  endtask

  task automatic tickBurst(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    $display("txn %0d: tick burst n=%0d -> state=%0d paddle=%0d", txnCnt, n, state, paddle_y);
  endtask

  task automatic loseLife();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tickBurst(PAUSE);
    if (mState == S_SERVE) pressServe(1'b0);
  endtask

  initial begin
    modelReset();
    mUp = 1'b0; mDown = 1'b0;
    @(negedge clk);
    resetDut();

    // Start a game: IDLE -> SERVE -> PLAY
    pressServe(1'b0);
    check("start_serve", 32'(state), S_SERVE);
    pressServe(1'b1);
    check("start_play", 32'(state), S_PLAY);

    // Randomized play
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       pressServe(1'($urandom_range(0, 1)));
      else if (r < 18) setButtons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r < 50) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else if (r < 80) step(1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < 85) step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      else if (r < 88) step(1'b0, 1'b1, 1'b1, 1'b0);
      else             tickBurst(PAUSE);
    end

    // Score carry and saturation
    resetDut();
    pressServe(1'b0); pressServe(1'b0);
    hitBurst(99);
    check("score_0099", 32'(score), 32'h0099);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("score_0100", 32'(score), 32'h0100);
    hitBurst(9999 - 100);
    check("score_9999", 32'(score), 32'h9999);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("score_sat", 32'(score), 32'h9999);
    check("speed_sat", 32'(speed), 7);

    // Hit and miss together: miss wins
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("hm_state", 32'(state), S_LOST);
    check("hm_score", 32'(score), 32'h9999);
    check("hm_lives", 32'(lives), 2);

    // Paddle clamps
    resetDut();
    pressServe(1'b0);
    setButtons(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("paddle_floor", 32'(paddle_y >= 10'(PMIN)), 1);
    end
    check("paddle_min", 32'(paddle_y), PMIN);
    setButtons(1'b0, 1'b1);
    tickBurst(5);
    check("paddle_down5", 32'(paddle_y), PMIN + 5 * STEP);
    setButtons(1'b1, 1'b1);
    tickBurst(10);
    check("paddle_both", 32'(paddle_y), PMIN + 5 * STEP);
    setButtons(1'b0, 1'b1);
    tickBurst(200);
    check("paddle_max", 32'(paddle_y), PMAX);
    setButtons(1'b0, 1'b0);

    // Lives, pause length and game over, with high-score tracking
    pressServe(1'b0);
    hitBurst(42);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tickBurst(PAUSE - 1);
    check("pause_59", 32'(state), S_LOST);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_60", 32'(state), S_SERVE);
    pressServe(1'b0);
    loseLife();
    loseLife();
    check("over_state", 32'(state), S_OVER);
    check("over_flag", 32'(game_over), 1);
    check("over_lives", 32'(lives), 0);
    check("hi_42", 32'(hiscore), HI_EN ? 32'h0042 : 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0);   // ignored outside PLAY
    pressServe(1'b0);
    check("over_idle", 32'(state), S_IDLE);
    check("held_score", 32'(score), 32'h0042);
    pressServe(1'b0); pressServe(1'b0);
    hitBurst(17);
    loseLife(); loseLife(); loseLife();
    check("over2_score", 32'(score), 32'h0017);
    check("hi_keep42", 32'(hiscore), HI_EN ? 32'h0042 : 32'h0);

    // Reset in mid-game with a pending hit
    pressServe(1'b0); pressServe(1'b0); pressServe(1'b0);
    hitBurst(3);
    txnCnt++;
    hit = 1'b1; rst_n = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clk);
    hit = 1'b0;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn %0d: mid-game reset -> state=%0d score=%h", txnCnt, state, score);
    @(negedge clk);
    check("post_rst_score", 32'(score), 0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PADDLE_STEP, 4: pixels moved per frame.
- PADDLE_MIN, 35: topmost paddle_y.
- PADDLE_MAX, 435: bottommost paddle_y.
- LIVES_INIT, 3: lives at game start, range 1..3.
- PAUSE_FRAMES, 60: frames held in LOST.
- SPEEDUP_HITS, 5: hits per speed increment.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: 100 MHz system clock.
- rst_n, in, 1: asynchronous active-low reset.
- frame_tick, in, 1: one-cycle pulse per VGA frame.
- btn_serve, in, 1: raw serve button.
- btn_up, in, 1: raw paddle-up button.
- btn_down, in, 1: raw paddle-down button.
- hit, in, 1: one-cycle pulse when the ball strikes the paddle.
- miss, in, 1: one-cycle pulse when the ball passes the paddle.
- state, out, 3: FSM state code.
- ball_en, out, 1: advance ball this cycle.
- ball_reset, out, 1: hold ball at serve position.
- paddle_y, out, 10: paddle top row.
- speed, out, 3: ball speed, 1..7.
- lives, out, 2: remaining lives.
- score, out, 16: four BCD digits, feeding the seven-segment scanner.
- hiscore, out, 16: BCD high score.
- game_over, out, 1: high in state OVER.

Function
REQ-003 All three buttons SHALL pass through a 2-flop synchronizer; serve acts only on the synchronized rising edge (one cycle).
REQ-004 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4.
REQ-005 IDLE -> SERVE on serve edge; on that transition score=0, lives=LIVES_INIT, speed=1, hit counter=0.
REQ-006 SERVE -> PLAY on serve edge.
REQ-007 PLAY -> LOST on miss; lives decrements by 1 in the same cycle.
REQ-008 LOST SHALL count PAUSE_FRAMES frame_ticks, then go to SERVE if lives>0, else OVER.
REQ-009 OVER -> IDLE on serve edge; score is held until the next IDLE->SERVE.
REQ-010 ball_en SHALL equal frame_tick while state==PLAY, and 0 otherwise (combinational, zero latency).
REQ-011 ball_reset SHALL be 1 in IDLE, SERVE, LOST and OVER.
REQ-012 Paddle movement SHALL update only on frame_tick, in SERVE and PLAY:
- up only: paddle_y = max(paddle_y-PADDLE_STEP, PADDLE_MIN).
- down only: paddle_y = min(paddle_y+PADDLE_STEP, PADDLE_MAX).
- both or neither: hold.
- No underflow or overflow of the 10-bit value.
REQ-013 hit in PLAY SHALL increment score by 1 in BCD with per-digit carry, saturating at 9999.
REQ-014 Every SPEEDUP_HITS hits in PLAY SHALL increment speed, saturating at 7; the hit counter wraps to 0.
REQ-015 hit and miss in the same cycle: miss wins, and score is unchanged.
REQ-016 hit and miss SHALL be ignored outside PLAY.
REQ-017 A serve edge coincident with frame_tick SHALL apply both effects independently.
REQ-018 Registered outputs SHALL update one cycle after the causing input edge.

Reset
REQ-019 While rst_n=0, outputs SHALL be:
- state=IDLE, paddle_y=(PADDLE_MIN+PADDLE_MAX)/2 truncated, speed=1.
- lives=LIVES_INIT, score=0, hiscore=0.
- synchronizers and pause counter cleared.
REQ-020 Reset asserted mid-game SHALL abort immediately to the reset values; no pending hit is applied.

Configuration
REQ-021 Macro PONG_HISCORE_EN:
- Defined: on entry to OVER, if score>hiscore (BCD compare), hiscore=score.
- Undefined: hiscore is tied to 16'h0000 and no compare logic exists.

Structure
REQ-022 Shared package pong_pkg SHALL hold:
- state encoding constants.
- BCD digit width.
- SCORE_MAX=16'h9999.
REQ-023 Sub-module bcd_inc4 (combinational saturating 4-digit BCD incrementer) SHALL be used for the score; the button synchronizers stay inline.

Verification
REQ-024 Reset, then serve edge twice -> state IDLE->SERVE->PLAY, lives=3, score=0000.
REQ-025 Score carry and saturation:
- In PLAY, score=0099 + 1 hit -> score=0100.
- From 9999 + 1 hit -> score stays 9999.
REQ-026 Paddle clamps, PADDLE_STEP=4:
- btn_up held for 200 frames -> paddle_y=35, never below.
- btn_up and btn_down both held -> no change.
REQ-027 Life loss, LIVES_INIT=3:
- 3 misses, each followed by 60 frames and a serve -> state OVER, game_over=1, lives=0.
- 59 frames after a miss -> still LOST.
REQ-028 Hit and miss in the same cycle -> score unchanged, lives decremented, state LOST.
REQ-029 With PONG_HISCORE_EN defined:
- Game ending at 0042 -> hiscore=0042.
- Next game ending at 0017 -> hiscore stays 0042.
